// File: rtl/emmc_crc_lanes.sv
// Multi-lane serial CRC engine for the eMMC CMD line (CRC7) and DAT bus (CRC16).
// Each lane accumulates its own CRC, then either shifts it out or checks it.
module emmc_crc_lanes #(
    parameter int          CRC_W = 16,
    parameter logic [15:0] POLY  = 16'h1021,
    parameter int          LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   din_valid,
    input  logic [LANES-1:0]       din,
    input  logic                   last,
    input  logic                   out_ready,
    output logic [LANES-1:0]       crc_out,
    output logic                   crc_out_valid,
    output logic [LANES*CRC_W-1:0] crc_q,
    output logic                   busy,
    output logic                   done,
    output logic [LANES-1:0]       crc_err
);

    localparam int                CW       = $clog2(CRC_W + 1);
    localparam logic [CW-1:0]     LAST_BIT = CW'(CRC_W - 1);
    localparam logic [CRC_W-1:0]  POLY_W   = POLY[CRC_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT,
        CHECK
    } state_t;

    state_t             state, state_n;
    logic [CRC_W-1:0]   crc_r [LANES];
    logic [CRC_W-1:0]   crc_n [LANES];
    logic [CW-1:0]      bitcnt, bitcnt_n;
    logic [LANES-1:0]   err_r, err_n;
    logic [LANES-1:0]   crc_err_n;
    logic               mode_r, mode_n;
    logic               done_n;
    logic [LANES-1:0]   msb;

    always_comb begin
        crc_q = '0;
        msb   = '0;
        for (int i = 0; i < LANES; i++) begin
            crc_q[i*CRC_W +: CRC_W] = crc_r[i];
            msb[i]                  = crc_r[i][CRC_W-1];
        end
    end

    assign crc_out       = (state == EMIT) ? msb : '0;
    assign crc_out_valid = (state == EMIT);
    assign busy          = (state != IDLE);

    always_comb begin
        state_n   = state;
        crc_n     = crc_r;
        bitcnt_n  = bitcnt;
        err_n     = err_r;
        crc_err_n = crc_err;
        mode_n    = mode_r;
        done_n    = 1'b0;
        if (start) begin
            // start overrides everything, including a same-cycle data bit
            state_n   = ACCUM;
            bitcnt_n  = '0;
            err_n     = '0;
            crc_err_n = '0;
            mode_n    = mode;
            for (int i = 0; i < LANES; i++) begin
                crc_n[i] = '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                end
                ACCUM: begin
                    if (din_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            crc_n[i] = {crc_r[i][CRC_W-2:0], 1'b0}
                                     ^ ((din[i] ^ msb[i]) ? POLY_W : '0);
                        end
                        if (last) begin
                            state_n  = mode_r ? CHECK : EMIT;
                            bitcnt_n = '0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        for (int i = 0; i < LANES; i++) begin
                            crc_n[i] = {crc_r[i][CRC_W-2:0], 1'b0};
                        end
                        bitcnt_n = bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (din_valid) begin
                        err_n = err_r | (din ^ msb);
                        for (int i = 0; i < LANES; i++) begin
                            crc_n[i] = {crc_r[i][CRC_W-2:0], 1'b0};
                        end
                        bitcnt_n = bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            crc_err_n = err_n;
                            done_n    = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bitcnt  <= '0;
            err_r   <= '0;
            crc_err <= '0;
            mode_r  <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                crc_r[i] <= '0;
            end
        end else begin
            state   <= state_n;
            bitcnt  <= bitcnt_n;
            err_r   <= err_n;
            crc_err <= crc_err_n;
            mode_r  <= mode_n;
            done    <= done_n;
            for (int i = 0; i < LANES; i++) begin
                crc_r[i] <= crc_n[i];
            end
        end
    end

endmodule

// File: tb/tb_emmc_crc_lanes.sv
// Directed bench for emmc_crc_lanes: a CRC7 CMD instance and a 4-lane CRC16 instance.
// Emitted bits and check-mode errors are scoreboarded against a bit-serial model.
module tb_emmc_crc_lanes;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_start = 0, s_mode = 0, s_dv = 0, s_last = 0, s_ordy = 0;
    logic [3:0]  s_din = '0;
    logic [3:0]  s_out;
    logic        s_ov, s_busy, s_done;
    logic [63:0] s_q;
    logic [3:0]  s_err;

    logic        c_start = 0, c_mode = 0, c_dv = 0, c_last = 0, c_ordy = 0;
    logic [0:0]  c_din = '0;
    logic [0:0]  c_out;
    logic        c_ov, c_busy, c_done;
    logic [6:0]  c_q;
    logic [0:0]  c_err;

    emmc_crc_lanes #(.CRC_W(16), .POLY(16'h1021), .LANES(4)) u_dat (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode),
        .din_valid(s_dv), .din(s_din), .last(s_last), .out_ready(s_ordy),
        .crc_out(s_out), .crc_out_valid(s_ov), .crc_q(s_q),
        .busy(s_busy), .done(s_done), .crc_err(s_err)
    );

    emmc_crc_lanes #(.CRC_W(7), .POLY(16'h0009), .LANES(1)) u_cmd (
        .clk(clk), .rst(rst), .start(c_start), .mode(c_mode),
        .din_valid(c_dv), .din(c_din), .last(c_last), .out_ready(c_ordy),
        .crc_out(c_out), .crc_out_valid(c_ov), .crc_q(c_q),
        .busy(c_busy), .done(c_done), .crc_err(c_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  sq [$];
    logic [3:0]  eq [$];
    logic [0:0]  cq [$];
    logic [0:0]  ceq [$];
    logic [15:0] mdl [4];
    logic [6:0]  c_mdl;

    function automatic logic [15:0] crc16f(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [6:0] crc7f(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic c_send(input logic [39:0] p, input logic m);
        @(negedge clk);
        c_start = 1'b1;
        c_mode  = m;
        @(negedge clk);
        c_start = 1'b0;
        c_mdl   = '0;
        for (int i = 39; i >= 0; i--) begin
            c_din  = p[i];
            c_mdl  = crc7f(c_mdl, p[i]);
            c_dv   = 1'b1;
            c_last = (i == 0);
            @(negedge clk);
        end
        c_dv   = 1'b0;
        c_last = 1'b0;
        chk("c_ov_after_last", c_ov, !m);
        chk("c_q_model", c_q, c_mdl);
        if (!m) begin
            for (int j = 6; j >= 0; j--) cq.push_back(c_mdl[j]);
        end
    endtask

    task automatic c_emit();
        int got, dones;
        logic [0:0] e;
        got   = 0;
        dones = 0;
        c_ordy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (c_done) begin
                dones++;
                chk("c_busy_at_done", c_busy, 0);
            end
            if (dones > 0) break;
            if (c_ov && c_ordy) begin
                e = (cq.size() > 0) ? cq.pop_front() : 1'bx;
                chk("c_crc_out", c_out, e);
                got++;
            end
            @(negedge clk);
        end
        c_ordy = 1'b0;
        chk("c_emit_bits", got, 7);
        chk("c_done_seen", dones, 1);
        @(negedge clk);
        chk("c_done_pulse", c_done, 0);
    endtask

    task automatic c_chk(input logic [6:0] bits);
        logic [0:0] e;
        ceq.push_back(bits != c_mdl);
        for (int j = 6; j >= 0; j--) begin
            c_din = bits[j];
            c_dv  = 1'b1;
            @(negedge clk);
        end
        c_dv = 1'b0;
        e = ceq.pop_front();
        chk("c_chk_done", c_done, 1);
        chk("c_crc_err", c_err, e);
    endtask

    task automatic s_send(input int nbits, input logic [31:0] pat, input logic m);
        logic b;
        @(negedge clk);
        s_start = 1'b1;
        s_mode  = m;
        @(negedge clk);
        s_start = 1'b0;
        for (int l = 0; l < 4; l++) mdl[l] = '0;
        for (int i = 0; i < nbits; i++) begin
            for (int l = 0; l < 4; l++) begin
                b         = pat[l*8 + 7 - (i % 8)];
                s_din[l]  = b;
                mdl[l]    = crc16f(mdl[l], b);
            end
            s_dv   = 1'b1;
            s_last = (i == nbits - 1);
            @(negedge clk);
        end
        s_dv   = 1'b0;
        s_last = 1'b0;
        s_din  = '0;
        chk("s_ov_after_last", s_ov, !m);
        chk("s_q_model", s_q, {mdl[3], mdl[2], mdl[1], mdl[0]});
        if (!m) begin
            for (int j = 15; j >= 0; j--)
                sq.push_back({mdl[3][j], mdl[2][j], mdl[1][j], mdl[0][j]});
        end
    endtask

    task automatic s_emit(input bit rnd);
        int got, dones;
        logic [3:0] e;
        got   = 0;
        dones = 0;
        for (int k = 0; k < 200; k++) begin
            s_ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_done) begin
                dones++;
                chk("s_busy_at_done", s_busy, 0);
            end
            if (dones > 0) break;
            if (s_ov && s_ordy) begin
                e = (sq.size() > 0) ? sq.pop_front() : 4'hx;
                chk("s_crc_out", s_out, e);
                got++;
            end
            @(negedge clk);
        end
        s_ordy = 1'b0;
        chk("s_emit_bits", got, 16);
        chk("s_done_seen", dones, 1);
        @(negedge clk);
        chk("s_done_pulse", s_done, 0);
    endtask

    task automatic s_chk(input logic [3:0] flip);
        logic [3:0] e;
        eq.push_back(flip);
        for (int j = 15; j >= 0; j--) begin
            for (int l = 0; l < 4; l++)
                s_din[l] = mdl[l][j] ^ ((j == 0) && flip[l]);
            s_dv = 1'b1;
            @(negedge clk);
        end
        s_dv  = 1'b0;
        s_din = '0;
        e = eq.pop_front();
        chk("s_chk_done", s_done, 1);
        chk("s_crc_err", s_err, e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s_q", s_q, 0);
        chk("rst_s_ctl", {s_out, s_ov, s_busy, s_done, s_err}, 0);
        chk("rst_c_all", {c_q, c_out, c_ov, c_busy, c_done, c_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // CMD0: CRC7 generate
        c_send(40'h40_0000_0000, 1'b0);
        chk("cmd0_crc7", c_q, 7'h4A);
        c_emit();

        // CMD17 argument 0: check good, then check with last bit flipped
        c_send(40'h51_0000_0000, 1'b1);
        chk("cmd17_crc7", c_q, 7'h2A);
        c_chk(7'b0101010);
        c_send(40'h51_0000_0000, 1'b1);
        c_chk(7'b0101011);

        // DAT CRC16 over 512 bytes of 0xFF on lane 0
        s_send(4096, 32'h0000_00FF, 1'b0);
        chk("dat_7fa1", s_q[15:0], 16'h7FA1);
        s_emit(1'b0);

        // Lane independence with a stalling consumer
        s_send(1024, 32'h0000_00FF, 1'b0);
        chk("lanes123_zero", s_q[63:16], 0);
        s_emit(1'b1);

        // din_valid while idle must not disturb the drained registers
        s_dv  = 1'b1;
        s_din = 4'hF;
        repeat (2) @(negedge clk);
        s_dv  = 1'b0;
        s_din = '0;
        chk("idle_dv_ignored", {s_q, s_busy}, 0);

        // Check-mode error isolation on lane 2, held until next start
        s_send(64, 32'hA53C_960F, 1'b1);
        s_chk(4'b0100);
        repeat (3) @(negedge clk);
        chk("err_held", s_err, 4'b0100);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("err_cleared", s_err, 0);

        // Abort at EMIT bit 5
        s_send(48, 32'h1234_5678, 1'b0);
        s_ordy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("abort_pre_bits", s_out, sq.pop_front());
            @(negedge clk);
        end
        s_ordy  = 1'b0;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        sq.delete();
        chk("abort_state", {s_busy, s_done, s_ov}, 3'b100);
        chk("abort_q_clr", s_q, 0);
        @(negedge clk);
        chk("abort_no_done", s_done, 0);
        s_send(48, 32'h1234_5678, 1'b0);
        s_emit(1'b1);

        // Asynchronous reset mid-ACCUM, then a clean frame
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_din   = 4'hF;
        s_dv    = 1'b1;
        repeat (10) @(negedge clk);
        s_dv  = 1'b0;
        s_din = '0;
        rst   = 1'b1;
        #1;
        chk("rst_async_q", s_q, 0);
        chk("rst_async_ctl", {s_out, s_ov, s_busy, s_done, s_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        s_send(4096, 32'h0000_00FF, 1'b0);
        chk("post_rst_7fa1", s_q[15:0], 16'h7FA1);
        s_emit(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/emmc_crc_lanes.md
# emmc_crc_lanes

Parametrised multi-lane CRC engine for the eMMC host datapath. It replaces single-purpose serial CRC7 logic with one block covering both cases: CMD-line CRC7 (LANES=1, CRC_W=7) and DAT-bus CRC16 (LANES=1/4/8, CRC_W=16). A frame-level state machine accumulates a CRC per lane over the payload. It then either serialises the CRC out for transmission (generate mode) or compares it bit by bit against the received CRC (check mode), reporting a per-lane error.

## Interface
- CRC_W, 16, CRC width in bits (7 for CMD, 16 for DAT)
- POLY, 16'h1021, generator polynomial without the x^CRC_W term; only the low CRC_W bits are used (CRC7 uses 7'h09)
- LANES, 4, number of independent serial lanes
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: clears all lane CRCs to 0, latches mode, enters ACCUM
- mode  in  1  sampled with start: 0 = generate, 1 = check
- din_valid  in  1  din carries one bit per lane this cycle
- din  in  LANES  payload bits during ACCUM; received CRC bits during CHECK
- last  in  1  qualifies the final payload bit; honoured only together with din_valid in ACCUM
- out_ready  in  1  consumer accepts the current crc_out bits
- crc_out  out  LANES  current CRC MSB of each lane (generate mode)
- crc_out_valid  out  1  high throughout EMIT
- crc_q  out  LANES*CRC_W  raw lane CRC registers; lane i occupies bits [i*CRC_W +: CRC_W]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at the end of EMIT or CHECK
- crc_err  out  LANES  per-lane mismatch result; valid from done until the next start

## Operation
- States: IDLE, ACCUM, EMIT, CHECK.
- IDLE: start -> ACCUM.
- ACCUM, on each din_valid:
  - every lane updates: fb = din[i] ^ crc[i][CRC_W-1]; crc[i] <= {crc[i][CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - With CRC_W=7 and POLY=7'h09 this is exactly the classic CMD CRC7 shift register.
  - din_valid & last: the bit is included, then the state moves to EMIT (mode 0) or CHECK (mode 1) and bitcnt is cleared.
- EMIT:
  - crc_out[i] = crc[i][CRC_W-1].
  - Each cycle with out_ready, every lane shifts left with 0 fill and bitcnt increments.
  - On the handshake where bitcnt == CRC_W-1: go to IDLE and pulse done. crc_err stays 0.
- CHECK:
  - Each cycle with din_valid, err[i] |= din[i] ^ crc[i][CRC_W-1]; then the lane shifts left and bitcnt increments.
  - On the CRC_W-th bit: crc_err <= final err (including that bit), done pulses, state goes to IDLE.
- bitcnt width: $clog2(CRC_W+1). Wrap-around is impossible because the state exits at CRC_W.
- start in any state, including mid-EMIT or mid-CHECK: aborts the frame, clears CRCs, err, crc_err and bitcnt, relatches mode, enters ACCUM. No done is issued for the aborted frame.
- din_valid in IDLE or EMIT is ignored. out_ready outside EMIT is ignored. last without din_valid is ignored.
- start and din_valid in the same cycle: start wins and the data bit is dropped.
- A zero-length payload is not supported; ACCUM is left only via last.

## Timing
- Reset values: state IDLE, every CRC 0, crc_out 0, crc_out_valid 0, crc_q 0, busy 0, done 0, crc_err 0, bitcnt 0.
- rst asserted mid-frame returns to these values immediately (asynchronous). No done is issued.
- crc_q reflects a din bit one cycle after it is sampled.
- If last is accepted at cycle t:
  - generate mode: crc_out_valid = 1 and crc_out shows the CRC MSBs from t+1.
  - check mode: the first CRC bit can be sampled at t+1.
- With out_ready held high, EMIT lasts exactly CRC_W cycles. done is high in the cycle after the last handshake, and busy is 0 in that same cycle.
- In CHECK, done and crc_err update together in the cycle after the CRC_W-th din_valid.
- busy rises the cycle after start.

## Test plan
- CMD CRC7: LANES=1, CRC_W=7, POLY=7'h09, mode 0; payload 40 00 00 00 00 MSB first -> crc_q = 7'h4A; emits 1,0,0,1,0,1,0 over 7 cycles; done pulses once.
- CMD17 argument 0: payload 51 00 00 00 00 -> crc_q = 7'h2A. In mode 1 followed by bits 0101010 -> crc_err = 0. Flipping the last bit -> crc_err = 1.
- DAT CRC16: LANES=1, payload 512 bytes 0xFF -> crc_q = 16'h7FA1.
- Lane independence: LANES=4, mode 0; lane 0 all 0xFF, lanes 1–3 all 0x00 (1024 bits/lane) -> lanes 1–3 emit 16 zeros. Lane 0 matches a LANES=1 run of the same stream. out_ready toggled randomly -> no bit lost or duplicated.
- Check-mode error isolation: LANES=4, correct CRC on lanes 0, 1, 3 and one flipped bit on lane 2 -> crc_err = 4'b0100, held until the next start.
- Abort/reset:
  - start issued at EMIT bit 5 -> no done, busy stays 1, CRCs restart from 0.
  - rst pulsed mid-ACCUM -> all outputs 0 within the same cycle; the next frame computes correct values.
